tuser_in_tuple_fifo: RTL and testbench
======================================

# tuser_in_tuple_fifo

Parametrised ingress tuple extractor for the SDNet wrapper. It snoops the AXI4-Stream packet interface and captures TUSER on the first accepted beat of every packet. The captured tuples are buffered in a DEPTH-entry FIFO and presented on a ready/valid tuple port, so the SDNet tuple input can apply backpressure independently of the packet stream. Tuples that find the FIFO full are dropped and counted.

## Interface
- TUSER_W, 128, width of tin_atuser and of the captured tuple.
- DEPTH, 16, tuple FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the saturating drop counter.
- tin_aclk  in  1  sole clock; all logic on rising edge.
- tin_arst  in  1  synchronous, active-high reset.
- tin_avalid  in  1  AXIS beat valid.
- tin_aready  in  1  AXIS beat ready (observed only); a beat is accepted when tin_avalid & tin_aready.
- tin_atuser  in  TUSER_W  AXIS sideband metadata.
- tin_atlast  in  1  AXIS last beat of packet.
- tin_valid  out  1  tuple available.
- tin_ready  in  1  tuple consumer ready.
- tin_data  out  TW  tuple; TW = TUSER_W, or TUSER_W+32 with TUSER_IN_TSTAMP_EN.
- tin_overflow  out  1  one-cycle pulse: SOP tuple dropped.
- tin_drop_cnt  out  CNT_W  saturating count of dropped tuples.

## Operation
- Beat acceptance: acc = tin_avalid & tin_aready. Beats with !acc are ignored entirely.
- FSM states: IDLE (expecting SOP), IN_PKT.
  - IDLE, acc & !tin_atlast: capture the SOP tuple, go to IN_PKT.
  - IDLE, acc & tin_atlast: single-beat packet; capture the SOP tuple, stay in IDLE.
  - IN_PKT, acc & tin_atlast: go to IDLE. Other accepted beats: stay in IN_PKT, no capture.
- Capture pushes {optional timestamp, tin_atuser} into the FIFO.
- Push is permitted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the tuple is dropped:
  - tin_overflow pulses for one cycle.
  - tin_drop_cnt increments and saturates at 2^CNT_W−1; it never wraps.
  - The FSM advances regardless of whether the tuple was dropped.
- FIFO is first-word-fall-through. tin_valid = !empty; tin_data = head entry.
- Pop occurs on tin_valid & tin_ready. tin_data is held stable while tin_valid & !tin_ready.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty are derived from the MSB compare.
- Simultaneous push and pop when empty: the FIFO still needs a push cycle first; no bypass path.
- Reset mid-packet:
  - FSM returns to IDLE and the FIFO is flushed.
  - The next accepted beat is treated as SOP, even if it belongs to the interrupted packet.

## Timing
- Reset values: tin_valid=0, tin_data=0, tin_overflow=0, tin_drop_cnt=0, FSM=IDLE, pointers=0, timestamp counter=0.
- Latency: SOP accepted at edge N, so tin_valid=1 from cycle N+1 (one cycle, FIFO previously empty).
- tin_valid falls the cycle after the last entry is popped.
- tin_overflow is registered and asserts in the cycle after the dropped SOP beat.
- Sustained throughput: one tuple pushed and one popped per cycle.

## Configuration
- TUSER_IN_TSTAMP_EN defined:
  - A free-running 32-bit cycle counter is instantiated; it resets to 0 and wraps 2^32−1→0.
  - Counter value at the SOP acceptance cycle is stored in tin_data[TW-1:TUSER_W].
  - TW = TUSER_W+32.
- Not defined: no counter is instantiated, and TW = TUSER_W.

## Structure
- Package tuser_in_pkg holds:
  - the state typedef (IDLE, IN_PKT);
  - the constant TS_W=32;
  - a function computing TW.
- Sub-module tuser_in_sfifo: generic synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty. The top holds the FSM, drop logic, counter and timestamp.

## Test plan
- Three packets of 4 beats, tuser 0xA, 0xB, 0xC on each SOP, tin_ready=1 → tin_data sequence 0xA, 0xB, 0xC. Each tuple valid one cycle after its SOP. Non-SOP tuser values are never emitted.
- Single-beat packets back-to-back for 8 cycles (tlast=1 every beat) → 8 tuples in order, no drops.
- tin_ready=0, DEPTH=16, 18 packets:
  - 16 tuples are held; tin_overflow pulses twice; tin_drop_cnt=2.
  - After releasing ready, exactly the first 16 tuples drain.
- FIFO full and a pop in the same cycle as an SOP → push accepted, no overflow, count unchanged.
- Beats with tin_avalid=1 and tin_aready=0, including one with tlast → no state change and no capture.
- Reset asserted mid-packet, then the remaining beats plus a new packet:
  - The first post-reset beat is captured as SOP.
  - tin_drop_cnt=0 and the timestamp restarts at 0 (with TUSER_IN_TSTAMP_EN).

Source files
------------

// File: rtl/tuser_in_tuple_fifo_pkg.sv
// tuser_in_pkg: shared types and constants for the ingress tuple extractor.
//   state_e      - packet-tracking FSM states (IDLE expects SOP, IN_PKT mid-packet)
//   TS_W         - width of the optional SOP timestamp
//   tuple_width  - tuple width for a given TUSER width; adds TS_W when the
//                  build defines TUSER_IN_TSTAMP_EN
package tuser_in_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  localparam int unsigned TS_W = 32;

`ifdef TUSER_IN_TSTAMP_EN
  localparam bit TSTAMP_EN = 1'b1;
`else
  localparam bit TSTAMP_EN = 1'b0;
`endif

  function automatic int unsigned tuple_width(input int unsigned tuser_w);
    return TSTAMP_EN ? tuser_w + TS_W : tuser_w;
  endfunction

endpackage

// File: rtl/tuser_in_tuple_fifo_if.sv
// tuser_in_tuple_fifo_if: AXIS snoop inputs plus the ready/valid tuple port.
//   tin_avalid/tin_aready/tin_atuser/tin_atlast - observed AXIS beat
//   tin_valid/tin_ready/tin_data                - tuple output handshake
//   tin_overflow/tin_drop_cnt                   - drop reporting
// Modports: slave = extractor side, master = stream source / tuple consumer.
interface tuser_in_tuple_fifo_if
  import tuser_in_pkg::*;
#(
  parameter int unsigned TUSER_W = 128,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned TW = tuple_width(TUSER_W);

  logic               tin_avalid;
  logic               tin_aready;
  logic [TUSER_W-1:0] tin_atuser;
  logic               tin_atlast;
  logic               tin_valid;
  logic               tin_ready;
  logic [TW-1:0]      tin_data;
  logic               tin_overflow;
  logic [CNT_W-1:0]   tin_drop_cnt;

  modport slave (
    input  tin_avalid, tin_aready, tin_atuser, tin_atlast, tin_ready,
    output tin_valid, tin_data, tin_overflow, tin_drop_cnt
  );

  modport master (
    output tin_avalid, tin_aready, tin_atuser, tin_atlast, tin_ready,
    input  tin_valid, tin_data, tin_overflow, tin_drop_cnt
  );

endinterface

// File: rtl/tuser_in_tuple_fifo_sfifo.sv
// tuser_in_sfifo: generic synchronous first-word-fall-through FIFO.
//   clk_i, rst_i (sync, active high)
//   push_i/data_i - write request; ignored when full unless a pop happens too
//   pop_i         - read request; ignored when empty
//   data_o        - head entry, forced to zero while empty
//   full_o/empty_o
module tuser_in_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Extra pointer MSB separates the full and empty cases of equal indices.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tuser_in_tuple_fifo.sv
// tuser_in_tuple_fifo: captures TUSER on the first accepted beat of each AXIS
// packet and queues it for a ready/valid tuple consumer.
//   tin_aclk, tin_arst (sync, active high)
//   tin (slave modport): AXIS snoop in, tuple out, overflow pulse, drop count
// Build option TUSER_IN_TSTAMP_EN: prepends a 32-bit free-running cycle count,
// sampled at the SOP beat, above the TUSER bits of each tuple.
module tuser_in_tuple_fifo
  import tuser_in_pkg::*;
#(
  parameter int unsigned TUSER_W = 128,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  tin_aclk,
  input  logic                  tin_arst,
  tuser_in_tuple_fifo_if.slave  tin
);
  localparam int unsigned TW = tuple_width(TUSER_W);

  state_e           state_q, state_d;
  logic             acc, sop, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [TW-1:0]    tuple, fifo_dout;
  logic             overflow_q;
  logic [CNT_W-1:0] cnt_q;

  assign acc  = tin.tin_avalid && tin.tin_aready;
  assign sop  = acc && (state_q == IDLE);
  assign pop  = !fifo_empty && tin.tin_ready;
  // A full FIFO still takes the tuple when the head leaves in the same cycle.
  assign drop = sop && fifo_full && !pop;

`ifdef TUSER_IN_TSTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge tin_aclk) begin
    if (tin_arst) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  assign tuple = {ts_q, tin.tin_atuser};
`else
  assign tuple = tin.tin_atuser;
`endif

  always_ff @(posedge tin_aclk) begin
    if (tin_arst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc && !tin.tin_atlast) state_d = IN_PKT;
      IN_PKT:  if (acc && tin.tin_atlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tin_aclk) begin
    if (tin_arst) begin
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      overflow_q <= drop;
      if (drop && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  tuser_in_sfifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (tin_aclk),
    .rst_i   (tin_arst),
    .push_i  (sop),
    .data_i  (tuple),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tin.tin_valid    = !fifo_empty;
  assign tin.tin_data     = fifo_dout;
  assign tin.tin_overflow = overflow_q;
  assign tin.tin_drop_cnt = cnt_q;

endmodule

// File: tb/tb_tuser_in_tuple_fifo.sv
module tb_tuser_in_tuple_fifo;
  import tuser_in_pkg::*;

  localparam int unsigned TUSER_W = 128;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CNT_W   = 16;

  typedef struct {
    logic               av, ar, tl, rdy;
    logic [TUSER_W-1:0] tu;
    logic               ev;
    logic [TUSER_W-1:0] ed;
    logic               eo;
    logic [CNT_W-1:0]   ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  tuser_in_tuple_fifo_if #(.TUSER_W(TUSER_W), .CNT_W(CNT_W)) bus ();

  tuser_in_tuple_fifo #(
    .TUSER_W (TUSER_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .tin_aclk (clk),
    .tin_arst (rst),
    .tin      (bus)
  );

  function automatic vec_t mk(input logic av, input logic ar, input logic tl,
                              input logic rdy, input logic [TUSER_W-1:0] tu,
                              input logic ev, input logic [TUSER_W-1:0] ed);
    vec_t v;
    v.av = av; v.ar = ar; v.tl = tl; v.rdy = rdy; v.tu = tu;
    v.ev = ev; v.ed = ed; v.eo = 1'b0; v.ec = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [TUSER_W-1:0] act,
                     input logic [TUSER_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic ar, input logic tl,
                       input logic rdy, input logic [TUSER_W-1:0] tu);
    bus.tin_avalid = av;
    bus.tin_aready = ar;
    bus.tin_atlast = tl;
    bus.tin_ready  = rdy;
    bus.tin_atuser = tu;
  endtask

  // Apply inputs for one cycle, then sample just after the edge.
  task automatic step(input logic av, input logic ar, input logic tl,
                      input logic rdy, input logic [TUSER_W-1:0] tu);
    drive(av, ar, tl, rdy, tu);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ev,
                         input logic [TUSER_W-1:0] ed, input logic eo,
                         input logic [CNT_W-1:0] ec);
    chk({name, "_valid"}, TUSER_W'(bus.tin_valid), TUSER_W'(ev));
    chk({name, "_data"}, bus.tin_data[TUSER_W-1:0], ed);
    chk({name, "_ovf"}, TUSER_W'(bus.tin_overflow), TUSER_W'(eo));
    chk({name, "_cnt"}, TUSER_W'(bus.tin_drop_cnt), TUSER_W'(ec));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, '0, 1'b0, '0);
    rst = 1'b0;

    // Three 4-beat packets: only the SOP tuser appears, one cycle later.
    for (int p = 0; p < 3; p++) begin
      vt.push_back(mk(1, 1, 0, 1, TUSER_W'(32'hA + p), 1, TUSER_W'(32'hA + p)));
      vt.push_back(mk(1, 1, 0, 1, TUSER_W'(32'h55),    0, '0));
      vt.push_back(mk(1, 1, 0, 1, TUSER_W'(32'h56),    0, '0));
      vt.push_back(mk(1, 1, 1, 1, TUSER_W'(32'h57),    0, '0));
    end
    // Eight back-to-back single-beat packets stream through at full rate.
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(1, 1, 1, 1, TUSER_W'(k), 1, TUSER_W'(k)));
    vt.push_back(mk(0, 0, 0, 1, '0, 0, '0));
    // Unaccepted beats (aready=0) must neither capture nor move the FSM.
    vt.push_back(mk(1, 0, 0, 1, TUSER_W'(32'hEE), 0, '0));
    vt.push_back(mk(1, 0, 1, 1, TUSER_W'(32'hEF), 0, '0));
    vt.push_back(mk(1, 1, 0, 0, TUSER_W'(32'h70), 1, TUSER_W'(32'h70)));
    vt.push_back(mk(1, 0, 1, 0, TUSER_W'(32'hE0), 1, TUSER_W'(32'h70)));
    vt.push_back(mk(1, 1, 0, 1, TUSER_W'(32'h71), 0, '0));
    vt.push_back(mk(1, 1, 1, 1, TUSER_W'(32'h72), 0, '0));
    vt.push_back(mk(1, 0, 0, 1, TUSER_W'(32'h73), 0, '0));
    vt.push_back(mk(1, 1, 1, 1, TUSER_W'(32'h74), 1, TUSER_W'(32'h74)));
    vt.push_back(mk(0, 0, 0, 1, '0, 0, '0));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].av, vt[i].ar, vt[i].tl, vt[i].rdy, vt[i].tu);
      chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].eo, vt[i].ec);
    end

    // Consumer stalled: 18 SOPs, the last two are dropped.
    for (int i = 0; i < 18; i++) begin
      step(1, 1, 1, 0, TUSER_W'(32'h100 + i));
      chk_out($sformatf("fill%0d", i), 1'b1, TUSER_W'(32'h100),
              (i >= 16), CNT_W'(i >= 16 ? i - 15 : 0));
    end
    step(0, 0, 0, 0, '0);
    chk_out("fill_idle", 1'b1, TUSER_W'(32'h100), 1'b0, CNT_W'(2));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_data", k), bus.tin_data[TUSER_W-1:0],
          TUSER_W'(32'h100 + k));
      step(0, 0, 0, 1, '0);
    end
    chk_out("drained", 1'b0, '0, 1'b0, CNT_W'(2));

    // Full FIFO with a pop in the same cycle as an SOP: push is accepted.
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0, TUSER_W'(32'h400 + i));
    chk_out("full16", 1'b1, TUSER_W'(32'h400), 1'b0, CNT_W'(2));
    step(1, 1, 1, 1, TUSER_W'(32'h200));
    chk_out("full_pop_sop", 1'b1, TUSER_W'(32'h401), 1'b0, CNT_W'(2));
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("fp_drain%0d_data", k), bus.tin_data[TUSER_W-1:0],
          TUSER_W'(32'h400 + k));
      step(0, 0, 0, 1, '0);
    end
    chk("fp_last_data", bus.tin_data[TUSER_W-1:0], TUSER_W'(32'h200));
    step(0, 0, 0, 1, '0);
    chk_out("fp_empty", 1'b0, '0, 1'b0, CNT_W'(2));

    // Reset in the middle of a packet; the next accepted beat is an SOP.
    step(1, 1, 0, 1, TUSER_W'(32'h300));
    chk_out("mid_sop", 1'b1, TUSER_W'(32'h300), 1'b0, CNT_W'(2));
    step(1, 1, 0, 1, TUSER_W'(32'h3FF));
    chk_out("mid_beat", 1'b0, '0, 1'b0, CNT_W'(2));
    rst = 1'b1;
    step(0, 0, 0, 1, '0);
    rst = 1'b0;
    chk_out("mid_reset", 1'b0, '0, 1'b0, '0);
    step(1, 1, 0, 1, TUSER_W'(32'h301));
    chk_out("post_rst_sop", 1'b1, TUSER_W'(32'h301), 1'b0, '0);
`ifdef TUSER_IN_TSTAMP_EN
    chk("post_rst_ts", TUSER_W'(bus.tin_data[TUSER_W+TS_W-1:TUSER_W]), '0);
`endif
    step(1, 1, 1, 1, TUSER_W'(32'h302));
    chk_out("post_rst_last", 1'b0, '0, 1'b0, '0);
    step(1, 1, 1, 1, TUSER_W'(32'h303));
    chk_out("post_rst_new", 1'b1, TUSER_W'(32'h303), 1'b0, '0);
    step(0, 0, 0, 1, '0);
    chk_out("post_rst_idle", 1'b0, '0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
